// File: rtl/ecc_serial_host.sv
// Serial host for an ECC point-multiplication core: it serialises one latched command
// onto bit lines (MSB first) and collects two serial result frames into parallel words.
module ecc_serial_host #(
   parameter int MAX_BITS = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [MAX_BITS-1:0] cmd_a,
   input  logic [MAX_BITS-1:0] cmd_b,
   input  logic [MAX_BITS-1:0] cmd_prime,
   input  logic [MAX_BITS-1:0] cmd_Px,
   input  logic [MAX_BITS-1:0] cmd_Py,
   input  logic [MAX_BITS-1:0] cmd_m,
   input  logic [MAX_BITS-1:0] cmd_nPx,
   input  logic [MAX_BITS-1:0] cmd_nPy,
   output logic                o_m_P_valid,
   output logic                o_nP_valid,
   output logic                o_mode,
   output logic                o_a,
   output logic                o_b,
   output logic                o_prime,
   output logic                o_Px,
   output logic                o_Py,
   output logic                o_m,
   output logic                o_nPx,
   output logic                o_nPy,
   input  logic                i_mP_valid,
   input  logic                i_mnP_valid,
   input  logic                i_mPx,
   input  logic                i_mPy,
   input  logic                i_mnPx,
   input  logic                i_mnPy,
   output logic                res_mP_valid,
   output logic                res_mnP_valid,
   output logic [MAX_BITS-1:0] res_mPx,
   output logic [MAX_BITS-1:0] res_mPy,
   output logic [MAX_BITS-1:0] res_mnPx,
   output logic [MAX_BITS-1:0] res_mnPy,
   output logic                res_err,
   output logic [2:0]          dbg_tx_state
);

   // Command handshake: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready is high only while the TX FSM is idle.

   localparam int CW = $clog2(MAX_BITS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE, START, MODE_HI, MODE_LO, MP_DATA, GAP, NP_START, NP_DATA
   } tx_state_e;

   function automatic logic [CW-1:0] last_idx(input logic [1:0] mode);
      logic [9:0] n;
      n = 10'd32 << mode;
      return CW'(n - 10'd1);
   endfunction

   tx_state_e           state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          mode_q, mode_d;
   logic [MAX_BITS-1:0] ops_q [8];
   logic [MAX_BITS-1:0] ops_d [8];
   logic                cmd_ready_q, cmd_ready_d;
   logic                m_p_valid_q, m_p_valid_d;
   logic                np_valid_q, np_valid_d;
   logic                mode_bit_q, mode_bit_d;
   logic [5:0]          mp_bits_q, mp_bits_d;
   logic [1:0]          np_bits_q, np_bits_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      for (int i = 0; i < 8; i++) ops_d[i] = ops_q[i];

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d  = START;
               mode_d   = cmd_mode;
               ops_d[0] = cmd_a;
               ops_d[1] = cmd_b;
               ops_d[2] = cmd_prime;
               ops_d[3] = cmd_Px;
               ops_d[4] = cmd_Py;
               ops_d[5] = cmd_m;
               ops_d[6] = cmd_nPx;
               ops_d[7] = cmd_nPy;
            end
         end
         START:   state_d = MODE_HI;
         MODE_HI: state_d = MODE_LO;
         MODE_LO: begin
            state_d = MP_DATA;
            cnt_d   = last_idx(mode_q);
         end
         MP_DATA: begin
            if (cnt_q == '0) state_d = GAP;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         GAP:     state_d = NP_START;
         NP_START: begin
            state_d = NP_DATA;
            cnt_d   = last_idx(mode_q);
         end
         NP_DATA: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so every line leaves a flop.
      cmd_ready_d = (state_d == IDLE);
      m_p_valid_d = (state_d == START);
      np_valid_d  = (state_d == NP_START);
      mode_bit_d  = 1'b0;
      if (state_d == MODE_HI) mode_bit_d = mode_d[1];
      if (state_d == MODE_LO) mode_bit_d = mode_d[0];
      mp_bits_d = '0;
      np_bits_d = '0;
      if (state_d == MP_DATA) begin
         for (int i = 0; i < 6; i++) mp_bits_d[i] = ops_d[i][cnt_d];
      end
      if (state_d == NP_DATA) begin
         for (int i = 0; i < 2; i++) np_bits_d[i] = ops_d[6+i][cnt_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= '0;
         cmd_ready_q <= 1'b0;
         m_p_valid_q <= 1'b0;
         np_valid_q  <= 1'b0;
         mode_bit_q  <= 1'b0;
         mp_bits_q   <= '0;
         np_bits_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         cmd_ready_q <= cmd_ready_d;
         m_p_valid_q <= m_p_valid_d;
         np_valid_q  <= np_valid_d;
         mode_bit_q  <= mode_bit_d;
         mp_bits_q   <= mp_bits_d;
         np_bits_q   <= np_bits_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) ops_q[i] <= ops_d[i];
   end

   // RX: channel 0 collects the mP frame, channel 1 the mnP frame.
   logic [1:0]          rx_vld, rx_bx, rx_by;
   logic [CW-1:0]       rx_last;
   logic [CW-1:0]       rx_cnt_q [2];
   logic [CW-1:0]       rx_cnt_d [2];
   logic [MAX_BITS-2:0] rx_shx_q [2];
   logic [MAX_BITS-2:0] rx_shx_d [2];
   logic [MAX_BITS-2:0] rx_shy_q [2];
   logic [MAX_BITS-2:0] rx_shy_d [2];
   logic [MAX_BITS-1:0] rx_nx [2];
   logic [MAX_BITS-1:0] rx_ny [2];
   logic [MAX_BITS-1:0] res_x_q [2];
   logic [MAX_BITS-1:0] res_x_d [2];
   logic [MAX_BITS-1:0] res_y_q [2];
   logic [MAX_BITS-1:0] res_y_d [2];
   logic [1:0]          res_vld_q, res_vld_d;
   logic                res_err_q, res_err_d;

   assign rx_vld = {i_mnP_valid, i_mP_valid};
   assign rx_bx  = {i_mnPx, i_mPx};
   assign rx_by  = {i_mnPy, i_mPy};

   always_comb begin
      rx_last   = last_idx(mode_q);
      res_vld_d = '0;
      res_err_d = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         rx_nx[ch]    = {rx_shx_q[ch], rx_bx[ch]};
         rx_ny[ch]    = {rx_shy_q[ch], rx_by[ch]};
         rx_cnt_d[ch] = rx_cnt_q[ch];
         rx_shx_d[ch] = rx_shx_q[ch];
         rx_shy_d[ch] = rx_shy_q[ch];
         res_x_d[ch]  = res_x_q[ch];
         res_y_d[ch]  = res_y_q[ch];
         if (rx_vld[ch]) begin
            // The shifter starts empty, so a finished word is already zero above N.
            if (rx_cnt_q[ch] >= rx_last) begin
               res_x_d[ch]   = rx_nx[ch];
               res_y_d[ch]   = rx_ny[ch];
               res_vld_d[ch] = 1'b1;
               rx_cnt_d[ch]  = '0;
               rx_shx_d[ch]  = '0;
               rx_shy_d[ch]  = '0;
            end else begin
               rx_cnt_d[ch]  = rx_cnt_q[ch] + CNT_ONE;
               rx_shx_d[ch]  = rx_nx[ch][MAX_BITS-2:0];
               rx_shy_d[ch]  = rx_ny[ch][MAX_BITS-2:0];
            end
         end else if (rx_cnt_q[ch] != '0) begin
            res_err_d    = 1'b1;
            rx_cnt_d[ch] = '0;
            rx_shx_d[ch] = '0;
            rx_shy_d[ch] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int ch = 0; ch < 2; ch++) begin
            rx_cnt_q[ch] <= '0;
            rx_shx_q[ch] <= '0;
            rx_shy_q[ch] <= '0;
            res_x_q[ch]  <= '0;
            res_y_q[ch]  <= '0;
         end
         res_vld_q <= '0;
         res_err_q <= 1'b0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            rx_cnt_q[ch] <= rx_cnt_d[ch];
            rx_shx_q[ch] <= rx_shx_d[ch];
            rx_shy_q[ch] <= rx_shy_d[ch];
            res_x_q[ch]  <= res_x_d[ch];
            res_y_q[ch]  <= res_y_d[ch];
         end
         res_vld_q <= res_vld_d;
         res_err_q <= res_err_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign o_m_P_valid   = m_p_valid_q;
   assign o_nP_valid    = np_valid_q;
   assign o_mode        = mode_bit_q;
   assign o_a           = mp_bits_q[0];
   assign o_b           = mp_bits_q[1];
   assign o_prime       = mp_bits_q[2];
   assign o_Px          = mp_bits_q[3];
   assign o_Py          = mp_bits_q[4];
   assign o_m           = mp_bits_q[5];
   assign o_nPx         = np_bits_q[0];
   assign o_nPy         = np_bits_q[1];
   assign res_mP_valid  = res_vld_q[0];
   assign res_mnP_valid = res_vld_q[1];
   assign res_mPx       = res_x_q[0];
   assign res_mPy       = res_y_q[0];
   assign res_mnPx      = res_x_q[1];
   assign res_mnPy      = res_y_q[1];
   assign res_err       = res_err_q;
   assign dbg_tx_state  = state_q;

endmodule

// File: tb/tb_ecc_serial_host.sv
// Bench for ecc_serial_host: cycle-exact TX frame expectations and an RX result
// scoreboard keyed by the cycle each result is due.
module tb_ecc_serial_host;
   localparam int MB = 256;
   typedef logic [MB-1:0] ops_t [8];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = '0;
   logic [MB-1:0] cmd_a = '0, cmd_b = '0, cmd_prime = '0, cmd_Px = '0;
   logic [MB-1:0] cmd_Py = '0, cmd_m = '0, cmd_nPx = '0, cmd_nPy = '0;
   logic          o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime;
   logic          o_Px, o_Py, o_m, o_nPx, o_nPy;
   logic          i_mP_valid = 1'b0, i_mnP_valid = 1'b0;
   logic          i_mPx = 1'b0, i_mPy = 1'b0, i_mnPx = 1'b0, i_mnPy = 1'b0;
   logic          res_mP_valid, res_mnP_valid, res_err;
   logic [MB-1:0] res_mPx, res_mPy, res_mnPx, res_mnPy;
   logic [2:0]    dbg_tx_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [11:0]     exp_q[$];
   logic [2*MB-1:0] exp_mp_q[$];
   logic [2*MB-1:0] exp_mnp_q[$];
   int              exp_mp_cyc_q[$];
   int              exp_mnp_cyc_q[$];
   int              exp_err_cyc_q[$];
   logic [MB-1:0]   last_mnpx = '0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ecc_serial_host #(.MAX_BITS(MB)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_prime(cmd_prime),
      .cmd_Px(cmd_Px), .cmd_Py(cmd_Py), .cmd_m(cmd_m), .cmd_nPx(cmd_nPx),
      .cmd_nPy(cmd_nPy), .o_m_P_valid(o_m_P_valid), .o_nP_valid(o_nP_valid),
      .o_mode(o_mode), .o_a(o_a), .o_b(o_b), .o_prime(o_prime), .o_Px(o_Px),
      .o_Py(o_Py), .o_m(o_m), .o_nPx(o_nPx), .o_nPy(o_nPy),
      .i_mP_valid(i_mP_valid), .i_mnP_valid(i_mnP_valid), .i_mPx(i_mPx),
      .i_mPy(i_mPy), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy),
      .res_mP_valid(res_mP_valid), .res_mnP_valid(res_mnP_valid),
      .res_mPx(res_mPx), .res_mPy(res_mPy), .res_mnPx(res_mnPx),
      .res_mnPy(res_mnPy), .res_err(res_err), .dbg_tx_state(dbg_tx_state)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] tx_vec();
      return {cmd_ready, o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime,
              o_Px, o_Py, o_m, o_nPx, o_nPy};
   endfunction

   function automatic logic [MB-1:0] rand256();
      logic [MB-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      return {rand256(), rand256()};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic accept_cmd(input logic [1:0] mode, input ops_t ops);
      int n, guard, idx;
      logic [11:0] v;
      n = 32 << mode;
      guard = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_mode = mode;
      cmd_a = ops[0]; cmd_b = ops[1]; cmd_prime = ops[2]; cmd_Px = ops[3];
      cmd_Py = ops[4]; cmd_m = ops[5]; cmd_nPx = ops[6]; cmd_nPy = ops[7];
      cmd_valid = 1'b1;
      // One expected output vector per cycle T+1 .. T+6+2N.
      for (int k = 1; k <= 6 + 2*n; k++) begin
         v = '0;
         if (k == 1) v[10] = 1'b1;
         if (k == 2) v[8] = mode[1];
         if (k == 3) v[8] = mode[0];
         if (k >= 4 && k <= 3 + n) begin
            idx = n - 1 - (k - 4);
            v[7] = ops[0][idx]; v[6] = ops[1][idx]; v[5] = ops[2][idx];
            v[4] = ops[3][idx]; v[3] = ops[4][idx]; v[2] = ops[5][idx];
         end
         if (k == 5 + n) v[9] = 1'b1;
         if (k >= 6 + n && k <= 5 + 2*n) begin
            idx = n - 1 - (k - 6 - n);
            v[1] = ops[6][idx]; v[0] = ops[7][idx];
         end
         if (k == 6 + 2*n) v[11] = 1'b1;
         exp_q.push_back(v);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic check_frame(input string name, input int max_cycles);
      int k;
      logic [11:0] v;
      k = 0;
      while (exp_q.size() > 0 && (max_cycles < 0 || k < max_cycles)) begin
         @(negedge clk);
         k++;
         v = exp_q.pop_front();
         check($sformatf("tx_%s_c%0d", name, k), tx_vec(), v);
      end
   endtask

   task automatic rx_drive(input int n, input int len_p, input logic [511:0] sx_p,
                           input logic [511:0] sy_p, input int len_n,
                           input logic [511:0] sx_n, input logic [511:0] sy_n);
      int c0, cnt, len, mx;
      logic [MB-1:0] ax, ay;
      logic [511:0] sx, sy;
      @(negedge clk);
      c0 = cyc;
      for (int ch = 0; ch < 2; ch++) begin
         len = (ch == 0) ? len_p : len_n;
         sx  = (ch == 0) ? sx_p : sx_n;
         sy  = (ch == 0) ? sy_p : sy_n;
         cnt = 0; ax = '0; ay = '0;
         for (int i = 0; i < len; i++) begin
            ax = {ax[MB-2:0], sx[len-1-i]};
            ay = {ay[MB-2:0], sy[len-1-i]};
            cnt++;
            if (cnt == n) begin
               if (ch == 0) begin
                  exp_mp_q.push_back({ax, ay});
                  exp_mp_cyc_q.push_back(c0 + i + 1);
               end else begin
                  exp_mnp_q.push_back({ax, ay});
                  exp_mnp_cyc_q.push_back(c0 + i + 1);
                  last_mnpx = ax;
               end
               cnt = 0; ax = '0; ay = '0;
            end
         end
         if (cnt != 0) exp_err_cyc_q.push_back(c0 + len + 1);
      end
      mx = (len_p > len_n) ? len_p : len_n;
      for (int i = 0; i <= mx; i++) begin
         if (i > 0) @(negedge clk);
         i_mP_valid  = (i < len_p);
         i_mPx       = (i < len_p) ? sx_p[len_p-1-i] : 1'b0;
         i_mPy       = (i < len_p) ? sy_p[len_p-1-i] : 1'b0;
         i_mnP_valid = (i < len_n);
         i_mnPx      = (i < len_n) ? sx_n[len_n-1-i] : 1'b0;
         i_mnPy      = (i < len_n) ? sy_n[len_n-1-i] : 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (res_mP_valid) begin
         if (exp_mp_q.size() == 0) check("mp_unexpected", res_mP_valid, 1'b0);
         else begin
            check("mp_value", {res_mPx, res_mPy}, exp_mp_q.pop_front());
            check("mp_cycle", cyc, exp_mp_cyc_q.pop_front());
         end
      end
      if (res_mnP_valid) begin
         if (exp_mnp_q.size() == 0) check("mnp_unexpected", res_mnP_valid, 1'b0);
         else begin
            check("mnp_value", {res_mnPx, res_mnPy}, exp_mnp_q.pop_front());
            check("mnp_cycle", cyc, exp_mnp_cyc_q.pop_front());
         end
      end
      if (res_err) begin
         if (exp_err_cyc_q.size() == 0) check("err_unexpected", res_err, 1'b0);
         else check("err_cycle", cyc, exp_err_cyc_q.pop_front());
      end
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      ops_t ops;
      logic [MB-1:0] p3;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_vec(), 12'h000);
      check("rst_res_mp", {res_mPx, res_mPy}, '0);
      check("rst_res_mnp", {res_mnPx, res_mnPy}, '0);
      check("rst_pulses", {res_mP_valid, res_mnP_valid, res_err}, 3'b000);
      rst = 1'b0;
      @(negedge clk);
      check("rst_release", tx_vec(), 12'h800);

      // Small mode-0 command; upper nP bits are random and must be ignored.
      ops[0] = 256'd2; ops[1] = 256'd3; ops[2] = 256'h17; ops[3] = 256'd5;
      ops[4] = 256'd1; ops[5] = 256'd7; ops[6] = rand256(); ops[7] = rand256();
      accept_cmd(2'd0, ops);
      check_frame("m0", -1);

      rx_drive(32, 32, 512'hDEADBEEF, rand512(), 0, '0, '0);
      rx_drive(32, 0, '0, '0, 32, rand512(), rand512());
      rx_drive(32, 0, '0, '0, 10, rand512(), rand512());
      check("mnp_hold", res_mnPx, last_mnpx);
      rx_drive(32, 32, rand512(), rand512(), 32, rand512(), rand512());
      rx_drive(32, 64, rand512(), rand512(), 0, '0, '0);
      rx_drive(32, 0, '0, '0, 40, rand512(), rand512());

      // Mode 1 with RX traffic running under the TX frame.
      for (int i = 0; i < 8; i++) ops[i] = rand256();
      accept_cmd(2'd1, ops);
      fork
         check_frame("m1", -1);
         rx_drive(64, 64, rand512(), rand512(), 70, rand512(), rand512());
      join

      for (int i = 0; i < 8; i++) ops[i] = rand256();
      accept_cmd(2'd2, ops);
      check_frame("m2", -1);

      p3 = (256'd1 << 255) + 256'd19;
      for (int i = 0; i < 8; i++) ops[i] = rand256();
      ops[2] = p3;
      accept_cmd(2'd3, ops);
      check_frame("m3", -1);
      rx_drive(256, 256, rand512(), rand512(), 256, rand512(), rand512());

      // Reset in the middle of MP_DATA of a mode-3 frame.
      for (int i = 0; i < 8; i++) ops[i] = rand256();
      accept_cmd(2'd3, ops);
      check_frame("pre_rst", 9);
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", tx_vec(), 12'h000);
      check("midrst_state", dbg_tx_state, 3'd0);
      check("midrst_res", {res_mPx, res_mnPx, res_mP_valid, res_mnP_valid, res_err}, '0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_release", tx_vec(), 12'h800);

      // Latched mode is back to 32 bits after reset.
      rx_drive(32, 32, rand512(), rand512(), 0, '0, '0);

      for (int i = 0; i < 8; i++) ops[i] = rand256();
      accept_cmd(2'd0, ops);
      check_frame("post_rst", -1);

      repeat (4) @(negedge clk);
      check("mp_q_left", exp_mp_q.size(), 0);
      check("mnp_q_left", exp_mnp_q.size(), 0);
      check("err_q_left", exp_err_cyc_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
